// File: rtl/timer_defs.sv
// Shared register map, CTRL bit positions and FSM encodings for timer_dev.
// CTRL[7:4] (PS) is only writable when TIMER_DEV_PRESCALE_EN is defined.
package timer_defs;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_MODE  = 1;
  localparam int CTRL_IM    = 3;
  localparam int CTRL_PS_LO = 4;

`ifdef TIMER_DEV_PRESCALE_EN
  localparam logic [7:0] CTRL_MASK = 8'hFB;
`else
  localparam logic [7:0] CTRL_MASK = 8'h0B;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Decoded bus events for one cycle.
  typedef struct packed {
    logic wr_ctrl;
    logic wr_preset;
    logic en_rise;
    logic en_off;
  } bus_evt_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old,
                                           input logic [31:0] din,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = din[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides enabled cycles by 2^ps; tick marks the enabled cycle that ends a period.
module timer_prescaler (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] ps,
  output logic       tick
);

  logic [14:0] cnt_q;
  logic [14:0] mask;

  assign mask = 15'((16'd1 << ps) - 16'd1);
  // Masked compare keeps a mid-period PS change from stalling the divider.
  assign tick = en && ((cnt_q & mask) == mask);

  always_ff @(posedge Clk) begin
    if (Reset || clr)
      cnt_q <= '0;
    else if (en)
      cnt_q <= tick ? '0 : cnt_q + 15'd1;
  end

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL / PRESET / COUNT words, IRQ on expiry.
// Optional prescaler on CTRL[7:4] enabled by macro TIMER_DEV_PRESCALE_EN.
module timer_dev
  import timer_defs::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              WE,
  input  logic [3:0]        BE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic              IRQ
);

  localparam int WW = ADDR_W - 2;

  state_e      state_q, state_d;
  logic [7:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_q;

  logic [WW-1:0] word;
  logic          is_ctrl, is_preset, is_count;
  bus_evt_t      ev;

  logic       do_load, do_dec, do_expire;
  logic       pre_en, pre_clr, tick;
  logic [3:0] ps;
  logic       unused_addr;

  assign word        = Addr[ADDR_W-1:2];
  assign unused_addr = ^Addr[1:0];
  assign is_ctrl     = (word == WW'(OFF_CTRL));
  assign is_preset   = (word == WW'(OFF_PRESET));
  assign is_count    = (word == WW'(OFF_COUNT));

  always_comb begin
    ev           = '0;
    ev.wr_ctrl   = WE && is_ctrl && (|BE);
    ev.wr_preset = WE && is_preset && (|BE);
    ev.en_rise   = ev.wr_ctrl && BE[0] && Din[CTRL_EN] && !ctrl_q[CTRL_EN];
    ev.en_off    = ev.wr_ctrl && BE[0] && !Din[CTRL_EN];
  end

`ifdef TIMER_DEV_PRESCALE_EN
  assign ps = ctrl_q[CTRL_PS_LO +: 4];
`else
  assign ps = 4'd0;
`endif

  assign pre_en  = (state_q == ST_CNT) && ctrl_q[CTRL_EN];
  assign pre_clr = (state_q == ST_LOAD);

  timer_prescaler u_prescaler (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (pre_clr),
    .en    (pre_en),
    .ps    (ps),
    .tick  (tick)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (ev.en_rise) state_d = ST_LOAD;
      ST_LOAD: state_d = (preset_q == 32'd0) ? ST_INT : ST_CNT;
      ST_CNT:  if (tick && count_q <= 32'd1) state_d = ST_INT;
      ST_INT:  state_d = ctrl_q[CTRL_MODE] ? ST_LOAD : ST_IDLE;
    endcase
    // Bus writes win over whatever the countdown would have done.
    if (ev.wr_preset)   state_d = ST_LOAD;
    else if (ev.en_off) state_d = ST_IDLE;
  end

  always_comb begin
    do_load   = 1'b0;
    do_dec    = 1'b0;
    do_expire = 1'b0;
    unique case (state_q)
      ST_LOAD: do_load   = 1'b1;
      ST_CNT:  do_dec    = tick && (count_q != 32'd0);
      ST_INT:  do_expire = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (ev.wr_preset) preset_q <= be_merge(preset_q, Din, BE);

      if (do_load)     count_q <= preset_q;
      else if (do_dec) count_q <= count_q - 32'd1;

      if (ev.wr_ctrl) begin
        if (BE[0]) ctrl_q <= Din[7:0] & CTRL_MASK;
        irq_q <= 1'b0;
      end else if (do_expire && !ev.wr_preset) begin
        irq_q <= irq_q | ctrl_q[CTRL_IM];
        if (!ctrl_q[CTRL_MODE]) ctrl_q[CTRL_EN] <= 1'b0;
      end
    end
  end

  assign IRQ = irq_q;

  always_comb begin
    Dout = '0;
    if (is_ctrl)        Dout = {24'd0, ctrl_q};
    else if (is_preset) Dout = preset_q;
    else if (is_count)  Dout = count_q;
  end

endmodule
